// File: rtl/md_unit_seq.sv
// md_unit_seq: multi-cycle multiply/divide unit feeding HI/LO.
// Computes the full result at issue time and holds it in pending registers.
// Busy is then held for a fixed latency before HI/LO are updated.
module md_unit_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  MDOp,
  input  logic [31:0] Data1,
  input  logic [31:0] Data2,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXL = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXL + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
  logic          wr_pend_q, wr_pend_d;

  logic        is_mul, is_div;
  logic [63:0] prod_s, prod_u, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;

  assign is_mul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
  assign is_div = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
  assign Start  = (is_mul || is_div) && (state_q == IDLE);
  assign Busy   = (state_q == RUN);
  assign HI     = hi_q;
  assign LO     = lo_q;

  // Full-precision product, signed or unsigned by opcode
  always_comb begin
    prod_s = $signed({{32{Data1[31]}}, Data1}) * $signed({{32{Data2[31]}}, Data2});
    prod_u = {32'd0, Data1} * {32'd0, Data2};
    prod   = (MDOp == OP_MULT) ? prod_s : prod_u;
  end

  // Sign-magnitude divide: truncates toward zero, remainder follows dividend.
  // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
  // A zero divisor is replaced by 1 only to keep the divider defined; the
  // result is discarded via wr_pend.
  always_comb begin
    a_neg   = (MDOp == OP_DIV) && Data1[31];
    b_neg   = (MDOp == OP_DIV) && Data2[31];
    a_mag   = a_neg ? (32'd0 - Data1) : Data1;
    b_mag   = b_neg ? (32'd0 - Data2) : Data2;
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quo     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem     = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Next-state: issue/mthi/mtlo in IDLE, countdown and commit in RUN
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_pend_d = hi_pend_q;
    lo_pend_d = lo_pend_q;
    wr_pend_d = wr_pend_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d   = RUN;
          cnt_d     = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          hi_pend_d = is_mul ? prod[63:32] : rem;
          lo_pend_d = is_mul ? prod[31:0]  : quo;
          wr_pend_d = is_mul || (Data2 != 32'd0);
        end else if (MDOp == OP_MTHI) begin
          hi_d = Data1;
        end else if (MDOp == OP_MTLO) begin
          lo_d = Data1;
        end
      end
      RUN: begin
        // Requests arriving while busy are dropped; the hazard unit stalls.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (wr_pend_q) begin
            hi_d = hi_pend_q;
            lo_d = lo_pend_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; async reset drops any in-flight operation
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_pend_q <= '0;
      lo_pend_q <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_pend_q <= hi_pend_d;
      lo_pend_q <= lo_pend_d;
      wr_pend_q <= wr_pend_d;
    end
  end
endmodule

// File: tb/tb_md_unit_seq.sv
// Scoreboard bench for md_unit_seq: expected HI/LO/latency pushed on issue,
// popped and compared when Busy falls.
module tb_md_unit_seq;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] Data1 = '0, Data2 = '0;
  logic        Start, Busy;
  logic [31:0] HI, LO;

  typedef struct { logic [31:0] hi; logic [31:0] lo; int lat; } exp_t;
  exp_t        sb[$];
  int          n_tests = 0, n_fail = 0;
  int          busy_cnt = 0;
  logic [31:0] model_hi = '0, model_lo = '0;

  md_unit_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .MDOp(MDOp), .Data1(Data1), .Data2(Data2),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Commit monitor: counts Busy cycles, compares at the falling edge of Busy
  always @(negedge Clk) begin
    if (Reset) busy_cnt = 0;
    else if (Busy) busy_cnt++;
    else if (busy_cnt != 0) begin
      if (sb.size() == 0) check("unexpected_commit", 64'(busy_cnt), 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("commit_hi", {32'd0, HI}, {32'd0, e.hi});
        check("commit_lo", {32'd0, LO}, {32'd0, e.lo});
        check("busy_len", 64'(busy_cnt), 64'(e.lat));
      end
      busy_cnt = 0;
    end
  end

  // Reference result in 64-bit integer arithmetic
  task automatic push_exp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb_, p, q, r;
    longint unsigned pu;
    e.hi = model_hi; e.lo = model_lo;
    sa = longint'($signed(a)); sb_ = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sb_; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 5; end
      3'd2: begin pu = {32'd0, a} * {32'd0, b}; e.hi = pu[63:32]; e.lo = pu[31:0]; e.lat = 5; end
      3'd3: begin
        e.lat = 10;
        if (b != 0) begin q = sa / sb_; r = sa % sb_; e.lo = q[31:0]; e.hi = r[31:0]; end
      end
      default: begin
        e.lat = 10;
        if (b != 0) begin e.lo = a / b; e.hi = a % b; end
      end
    endcase
    model_hi = e.hi; model_lo = e.lo;
    sb.push_back(e);
  endtask

  // Drive one op from IDLE for a single cycle
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic exp_start;
    exp_start = (op >= 3'd1 && op <= 3'd4);
    MDOp = op; Data1 = a; Data2 = b;
    #1 check("start", {63'd0, Start}, {63'd0, exp_start});
    if (exp_start) push_exp(op, a, b);
    @(posedge Clk); #1;
    MDOp = 3'd0;
    if (op == 3'd5) model_hi = a;
    if (op == 3'd6) model_lo = a;
    if (!exp_start) begin
      check("busy_noissue", {63'd0, Busy}, 64'd0);
      check("hi_direct", {32'd0, HI}, {32'd0, model_hi});
      check("lo_direct", {32'd0, LO}, {32'd0, model_lo});
    end
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge Clk); #1;
      if (!Busy && sb.size() == 0) break;
    end
    if (i == 40) check("timeout", 64'(sb.size()), 64'd0);
    @(posedge Clk); #1;
  endtask

  initial begin
    logic [31:0] prev_lo;
    repeat (2) @(negedge Clk);
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_hi", {32'd0, HI}, 64'd0);
    check("rst_lo", {32'd0, LO}, 64'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Tests 1-3 and sign/overflow corners
    issue(3'd1, 32'hFFFF_FFFF, 32'h2); wait_done();
    issue(3'd2, 32'hFFFF_FFFF, 32'h2); wait_done();
    issue(3'd3, 32'hFFFF_FFF9, 32'h2); wait_done();
    issue(3'd4, 32'd7, 32'd2);         wait_done();
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
    issue(3'd3, 32'd7, 32'hFFFF_FFFE); wait_done();
    issue(3'd1, 32'h8000_0000, 32'h8000_0000); wait_done();
    issue(3'd2, 32'hDEAD_BEEF, 32'h1234_5678); wait_done();

    // Test 4: divide by zero leaves preloaded HI/LO
    issue(3'd5, 32'h11, 32'h0);
    issue(3'd6, 32'h22, 32'h0);
    issue(3'd3, 32'd100, 32'd0); wait_done();
    issue(3'd4, 32'hFFFF_FFFF, 32'd0); wait_done();

    // Reserved/none opcodes change nothing
    issue(3'd7, 32'hAAAA_AAAA, 32'd1);
    issue(3'd0, 32'hBBBB_BBBB, 32'd1);

    // Test 5: mtlo and divu during Busy are dropped
    prev_lo = model_lo;
    issue(3'd1, 32'd3, 32'd4);
    MDOp = 3'd6; Data1 = 32'h55;
    #1 check("start_busy_mtlo", {63'd0, Start}, 64'd0);
    @(posedge Clk); #1;
    check("lo_frozen1", {32'd0, LO}, {32'd0, prev_lo});
    MDOp = 3'd4; Data1 = 32'd9; Data2 = 32'd2;
    #1 check("start_busy_divu", {63'd0, Start}, 64'd0);
    @(posedge Clk); #1;
    MDOp = 3'd0;
    check("lo_frozen2", {32'd0, LO}, {32'd0, prev_lo});
    wait_done();
    check("t5_hi", {32'd0, HI}, 64'd0);
    check("t5_lo", {32'd0, LO}, 64'd12);

    // Test 6: reset in the 4th Busy cycle of a div
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    sb.delete();
    model_hi = '0; model_lo = '0;
    #1;
    check("rst_mid_busy", {63'd0, Busy}, 64'd0);
    check("rst_mid_hi", {32'd0, HI}, 64'd0);
    check("rst_mid_lo", {32'd0, LO}, 64'd0);
    @(negedge Clk); @(negedge Clk);
    Reset = 1'b0;
    repeat (15) @(negedge Clk);
    check("no_late_busy", {63'd0, Busy}, 64'd0);
    check("no_late_hi", {32'd0, HI}, 64'd0);
    check("no_late_lo", {32'd0, LO}, 64'd0);

    // Unit still works after the abort
    @(posedge Clk); #1;
    issue(3'd4, 32'd100, 32'd7); wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
